// File: rtl/mux4to1_hdl.sv
// Registered 4:1 multiplexer with one cycle of latency and an all-zero async reset.
// Define MUX4TO1_HDL_PARITY_EN to add o_par, the registered even parity of o_y.
module mux4to1_hdl #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_d,
  input  logic [1:0]       i_sel,
`ifdef MUX4TO1_HDL_PARITY_EN
  output logic [WIDTH-1:0] o_y,
  output logic             o_par
`else
  output logic [WIDTH-1:0] o_y
`endif
);

  logic [WIDTH-1:0] sel_data;

  // Fully decoded select; only the chosen source reaches the output flop.
  always_comb begin
    sel_data = i_a;
    case (i_sel)
      2'b00: sel_data = i_a;
      2'b01: sel_data = i_b;
      2'b10: sel_data = i_c;
      2'b11: sel_data = i_d;
      default: sel_data = i_a;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_y <= '0;
    end else begin
      o_y <= sel_data;
    end
  end

`ifdef MUX4TO1_HDL_PARITY_EN
  // Parity is taken from the value being captured so it lines up with o_y.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_par <= 1'b0;
    end else begin
      o_par <= ^sel_data;
    end
  end
`endif

endmodule

// File: tb/tb_mux4to1_hdl.sv
// Scoreboard bench for mux4to1_hdl: one WIDTH=1 and one WIDTH=8 instance share clock, reset and select.
// Expected results are queued when inputs are driven and popped one cycle later.
module tb_mux4to1_hdl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sel;
  logic       a1, b1, c1, d1, y1;
  logic [7:0] a8, b8, c8, d8, y8;
`ifdef MUX4TO1_HDL_PARITY_EN
  logic       par1, par8;
`endif

  typedef struct {
    logic [7:0] y;
    logic       par;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];
  exp_t e;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  always #5 clk = ~clk;

  mux4to1_hdl #(.WIDTH(1)) u_dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_a     (a1),
    .i_b     (b1),
    .i_c     (c1),
    .i_d     (d1),
    .i_sel   (sel),
`ifdef MUX4TO1_HDL_PARITY_EN
    .o_y     (y1),
    .o_par   (par1)
`else
    .o_y     (y1)
`endif
  );

  mux4to1_hdl #(.WIDTH(8)) u_dut8 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_a     (a8),
    .i_b     (b8),
    .i_c     (c8),
    .i_d     (d8),
    .i_sel   (sel),
`ifdef MUX4TO1_HDL_PARITY_EN
    .o_y     (y8),
    .o_par   (par8)
`else
    .o_y     (y8)
`endif
  );

  function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] a, b, c, d);
    case (s)
      2'b00: return a;
      2'b01: return b;
      2'b10: return c;
      default: return d;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    sel = 2'b11;
    {a1, b1, c1, d1} = 4'b1111;
    a8 = 8'hFF; b8 = 8'hFF; c8 = 8'hFF; d8 = 8'hFF;
    #1;
    n_compared++;
    if (y1 !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_y1: got %b expected 0", y1);
    end
    n_compared++;
    if (y8 !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_y8: got %h expected 00", y8);
    end
`ifdef MUX4TO1_HDL_PARITY_EN
    n_compared++;
    if (par8 !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_par8: got %b expected 0", par8);
    end
`endif
    @(posedge clk);
    #1;
    n_compared++;
    if (y8 !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_hold_y8: got %h expected 00", y8);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_width1();
    logic [6:0] tbl [5];
    tbl[0] = {2'b00, 4'b0000, 1'b0};
    tbl[1] = {2'b01, 4'b0001, 1'b0};
    tbl[2] = {2'b10, 4'b0011, 1'b1};
    tbl[3] = {2'b11, 4'b0011, 1'b1};
    tbl[4] = {2'b00, 4'b0000, 1'b0};
    for (int i = 0; i < 5; i++) begin
      sel = tbl[i][6:5];
      {a1, b1, c1, d1} = tbl[i][4:1];
      q1.push_back('{y: {7'd0, tbl[i][0]}, par: tbl[i][0]});
      @(negedge clk);
      e = q1.pop_front();
      n_compared++;
      if (y1 !== e.y[0]) begin
        n_mismatched++;
        $display("[TB] FAIL width1_step%0d: got %b expected %b", i, y1, e.y[0]);
      end
`ifdef MUX4TO1_HDL_PARITY_EN
      n_compared++;
      if (par1 !== e.par) begin
        n_mismatched++;
        $display("[TB] FAIL width1_par%0d: got %b expected %b", i, par1, e.par);
      end
`endif
    end
  endtask

  task automatic test_width8_sweep();
    logic [7:0] exp_tbl [4];
    logic [7:0] prev;
    exp_tbl[0] = 8'h5A; exp_tbl[1] = 8'hA5; exp_tbl[2] = 8'hFF; exp_tbl[3] = 8'h00;
    a8 = 8'h5A; b8 = 8'hA5; c8 = 8'hFF; d8 = 8'h00;
    prev = y8;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      q8.push_back('{y: exp_tbl[i], par: 1'b0});
      #2;
      n_compared++;
      if (y8 !== prev) begin
        n_mismatched++;
        $display("[TB] FAIL sweep_latency%0d: got %h expected %h", i, y8, prev);
      end
      @(negedge clk);
      e = q8.pop_front();
      prev = e.y;
      n_compared++;
      if (y8 !== e.y) begin
        n_mismatched++;
        $display("[TB] FAIL sweep_y%0d: got %h expected %h", i, y8, e.y);
      end
`ifdef MUX4TO1_HDL_PARITY_EN
      n_compared++;
      if (par8 !== e.par) begin
        n_mismatched++;
        $display("[TB] FAIL sweep_par%0d: got %b expected %b", i, par8, e.par);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v8;
    logic [7:0] v1;
    for (int i = 0; i < 40; i++) begin
      sel = 2'($urandom_range(0, 3));
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom); d8 = 8'($urandom);
      {a1, b1, c1, d1} = 4'($urandom);
      v8 = pick(sel, a8, b8, c8, d8);
      v1 = pick(sel, {7'd0, a1}, {7'd0, b1}, {7'd0, c1}, {7'd0, d1});
      q8.push_back('{y: v8, par: ^v8});
      q1.push_back('{y: v1, par: v1[0]});
      @(negedge clk);
      e = q8.pop_front();
      n_compared++;
      if (y8 !== e.y) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_y8_%0d: got %h expected %h", i, y8, e.y);
      end
`ifdef MUX4TO1_HDL_PARITY_EN
      n_compared++;
      if (par8 !== e.par) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_par8_%0d: got %b expected %b", i, par8, e.par);
      end
`endif
      e = q1.pop_front();
      n_compared++;
      if (y1 !== e.y[0]) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_y1_%0d: got %b expected %b", i, y1, e.y[0]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    sel = 2'b00;
    a8 = 8'hC3;
    a1 = 1'b1;
    @(negedge clk);
    a8 = 8'h77;
    a1 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_compared++;
    if (y8 !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL midflight_async_y8: got %h expected 00", y8);
    end
    n_compared++;
    if (y1 !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL midflight_async_y1: got %b expected 0", y1);
    end
    @(posedge clk);
    #1;
    n_compared++;
    if (y8 !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL midflight_hold_y8: got %h expected 00", y8);
    end
    @(negedge clk);
    a8 = 8'h3C;
    rst_n = 1'b1;
    q8.push_back('{y: 8'h3C, par: 1'b0});
    #2;
    n_compared++;
    if (y8 !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL midflight_release_y8: got %h expected 00", y8);
    end
    @(negedge clk);
    e = q8.pop_front();
    n_compared++;
    if (y8 !== e.y) begin
      n_mismatched++;
      $display("[TB] FAIL midflight_first_y8: got %h expected %h", y8, e.y);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_width1();
    test_width8_sweep();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mux4to1_hdl.md
MUX4TO1_HDL -- requirements
Module: mux4to1_hdl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the data width of every data input and of o_y.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port i_a, input, WIDTH bits: data selected when i_sel=2'b00.
REQ-005 The block SHALL have port i_b, input, WIDTH bits: data selected when i_sel=2'b01.
REQ-006 The block SHALL have port i_c, input, WIDTH bits: data selected when i_sel=2'b10.
REQ-007 The block SHALL have port i_d, input, WIDTH bits: data selected when i_sel=2'b11.
REQ-008 The block SHALL have port i_sel, input, 2 bits: source select.
REQ-009 The block SHALL have port o_y, output, WIDTH bits: registered selected data.
REQ-010 The block SHALL have port o_par, output, 1 bit: registered even parity of o_y; present only when MUX4TO1_HDL_PARITY_EN is defined.

Function
REQ-011 The block SHALL compute the selection as i_sel=00 -> i_a, 01 -> i_b, 10 -> i_c, 11 -> i_d, with no priority logic and no other cases.
REQ-012 The block SHALL register the selected value into o_y on every rising edge of i_clk, giving exactly 1 cycle of latency from i_sel and data inputs to o_y.
REQ-013 The block SHALL have no enable or hold function; o_y SHALL reflect the inputs sampled at the most recent rising edge.
REQ-014 The block SHALL let simultaneous changes of i_sel and data inputs in the same cycle appear together on o_y one cycle later, with no intermediate value.
REQ-015 The block SHALL not register the unselected inputs; they SHALL have no effect on o_y.
REQ-016 The block SHALL keep the selection path bit-exact per bit; no width extension or truncation SHALL occur.
REQ-017 The block SHALL drive o_y (and o_par) directly from flops, with no combinational input-to-output path.

Reset
REQ-018 The block SHALL clear o_y to all-zeros immediately on assertion of i_rst_n=0, independent of i_clk.
REQ-019 The block SHALL clear o_par to 0 during reset, when present.
REQ-020 The block SHALL hold outputs at reset values while i_rst_n=0; the first capture SHALL occur on the first rising edge of i_clk after deassertion.
REQ-021 The block SHALL abandon any in-flight value if reset is asserted mid-operation; that value SHALL never appear on o_y.

Configuration
REQ-022 With macro MUX4TO1_HDL_PARITY_EN defined, the block SHALL include port o_par and a parity flop updated each rising edge with the XOR of all bits of the newly selected value, aligned with o_y.
REQ-023 Without MUX4TO1_HDL_PARITY_EN, the block SHALL omit port o_par and all parity logic, with o_y behaviour unchanged.

Verification
REQ-024 The bench SHALL cover reset: with i_rst_n=0 and any inputs, o_y=0 (and o_par=0) with no clock edge required.
REQ-025 The bench SHALL cover sel=00 with a=0,b=0,c=0,d=0 (WIDTH=1): o_y=0 one cycle later.
REQ-026 The bench SHALL cover sel=01 with a=0,b=0,c=0,d=1: o_y=0 (b chosen, d ignored); then sel=10 with c=1: o_y=1.
REQ-027 The bench SHALL cover sel=11 with c=1,d=1: o_y=1; then sel=00 with all inputs 0: o_y=0, each one cycle after the input change.
REQ-028 The bench SHALL cover WIDTH=8 with a=8'h5A, b=8'hA5, c=8'hFF, d=8'h00 over a sel sweep 00..11: o_y=5A, A5, FF, 00 in consecutive cycles, with o_par=0,0,0,0 when the parity macro is defined.
REQ-029 The bench SHALL cover reset asserted between an input change and the next edge: o_y=0 and the pending value never appears after release.
